// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: state codes, select codes, opcodes.
// Also holds the registered decode bundle and the branch-condition helper.
package rv32i_pkg;

  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_U = 3'd5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_MEM    = 3'd4;
  localparam state_t S_WB     = 3'd5;
  localparam state_t S_TRAP   = 3'd6;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic [3:0] alu_sel;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] wb_sel;
    logic       br_un;
    logic       mem_rw;
    logic       is_branch;
    logic       is_mem;
    logic       is_jump;
  } ctrl_t;

  // funct3 010/011 are not branch conditions and never take.
  function automatic logic br_taken(input logic [2:0] funct3, input logic br_eq,
                                    input logic br_lt);
    case (funct3)
      3'b000:         br_taken = br_eq;
      3'b001:         br_taken = !br_eq;
      3'b100, 3'b110: br_taken = br_lt;
      3'b101, 3'b111: br_taken = !br_lt;
      default:        br_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Instruction/data memory handshake bundle between the control FSM and the memories.
interface rv32i_multicycle_ctrl_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_ack;
  logic        MemRW;

  modport master (
    output imem_req, dmem_req, MemRW,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, MemRW,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/rv32i_decoder.sv
// Combinational IR field decode into datapath selects; registered by the FSM in DECODE.
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output ctrl_t      ctrl_o,
  output logic       legal_o
);

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    ctrl_o         = '0;
    ctrl_o.alu_sel = ALU_ADD;
    legal_o        = 1'b1;
    case (opcode_i)
      OPC_OP: begin
        ctrl_o.imm_sel = IMM_R;
        ctrl_o.alu_sel = alu_op(funct3_i, funct7b5_i);
        ctrl_o.wb_sel  = WB_ALU;
      end
      OPC_OP_IMM: begin
        // inst[30] only means something for shifts-right here; ADDI has no subtract form.
        ctrl_o.imm_sel = IMM_I;
        ctrl_o.alu_sel = alu_op(funct3_i, funct7b5_i && (funct3_i == 3'b101));
        ctrl_o.b_sel   = 1'b1;
        ctrl_o.wb_sel  = WB_ALU;
      end
      OPC_LOAD: begin
        ctrl_o.imm_sel = IMM_I;
        ctrl_o.b_sel   = 1'b1;
        ctrl_o.wb_sel  = WB_MEM;
        ctrl_o.is_mem  = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.imm_sel = IMM_S;
        ctrl_o.b_sel   = 1'b1;
        ctrl_o.mem_rw  = 1'b1;
        ctrl_o.is_mem  = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.imm_sel   = IMM_B;
        ctrl_o.a_sel     = 1'b1;
        ctrl_o.b_sel     = 1'b1;
        ctrl_o.br_un     = funct3_i[1];
        ctrl_o.is_branch = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.imm_sel = IMM_J;
        ctrl_o.a_sel   = 1'b1;
        ctrl_o.b_sel   = 1'b1;
        ctrl_o.wb_sel  = WB_PC4;
        ctrl_o.is_jump = 1'b1;
      end
      OPC_JALR: begin
        ctrl_o.imm_sel = IMM_I;
        ctrl_o.b_sel   = 1'b1;
        ctrl_o.wb_sel  = WB_PC4;
        ctrl_o.is_jump = 1'b1;
      end
      OPC_LUI: begin
        ctrl_o.imm_sel = IMM_U;
        ctrl_o.alu_sel = ALU_PASSB;
        ctrl_o.b_sel   = 1'b1;
        ctrl_o.wb_sel  = WB_ALU;
      end
      OPC_AUIPC: begin
        ctrl_o.imm_sel = IMM_U;
        ctrl_o.a_sel   = 1'b1;
        ctrl_o.b_sel   = 1'b1;
        ctrl_o.wb_sel  = WB_ALU;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch over req/ack, decode into registered selects,
// sequence EXEC/MEM/WB; illegal opcodes and ack timeouts park the core in TRAP.
module rv32i_multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  rv32i_multicycle_ctrl_if.master        mem,
  output logic [31:0]                    inst,
  output logic [2:0]                     ImmSel,
  input  logic                           BrEq,
  input  logic                           BrLT,
  output logic                           BrUn,
  output logic                           ASel,
  output logic                           BSel,
  output logic [3:0]                     ALUSel,
  output logic [1:0]                     WBSel,
  output logic                           RegWEn,
  output logic                           PCSel,
  output logic                           PCWrite,
  output logic                           illegal,
  output logic                           bus_err
);

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        illegal_q, illegal_d;
  logic        bus_err_q, bus_err_d;

  ctrl_t       dec_ctrl;
  logic        dec_legal;

  rv32i_decoder u_dec (
    .opcode_i   (inst_q[6:0]),
    .funct3_i   (inst_q[14:12]),
    .funct7b5_i (inst_q[30]),
    .ctrl_o     (dec_ctrl),
    .legal_o    (dec_legal)
  );

  // cnt only advances while a request is outstanding; every other path clears it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    inst_d    = inst_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem.imem_ack) begin
          inst_d  = mem.imem_rdata;
          state_d = S_DECODE;
        end else if (cnt_q == TMO_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        ctrl_d = dec_ctrl;
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        if (ctrl_q.is_branch)   state_d = S_FETCH;
        else if (ctrl_q.is_mem) state_d = S_MEM;
        else                    state_d = S_WB;
      end
      S_MEM: begin
        if (mem.dmem_ack) begin
          state_d = ctrl_q.mem_rw ? S_FETCH : S_WB;
        end else if (cnt_q == TMO_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      inst_q    <= NOP;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inst_q    <= inst_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign mem.imem_req = (state_q == S_FETCH);
  assign mem.dmem_req = (state_q == S_MEM);
  assign mem.MemRW    = (state_q == S_MEM) && ctrl_q.mem_rw;

  assign inst    = inst_q;
  assign ImmSel  = ctrl_q.imm_sel;
  assign ALUSel  = ctrl_q.alu_sel;
  assign ASel    = ctrl_q.a_sel;
  assign BSel    = ctrl_q.b_sel;
  assign WBSel   = ctrl_q.wb_sel;
  assign BrUn    = ctrl_q.br_un;
  assign RegWEn  = (state_q == S_WB) && (inst_q[11:7] != 5'd0);
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

  // A store retires in the ack cycle itself, so PCWrite follows dmem_ack there.
  always_comb begin
    PCWrite = 1'b0;
    PCSel   = 1'b0;
    case (state_q)
      S_EXEC: begin
        PCWrite = ctrl_q.is_branch;
        PCSel   = ctrl_q.is_branch && br_taken(inst_q[14:12], BrEq, BrLT);
      end
      S_MEM:  PCWrite = mem.dmem_ack && ctrl_q.mem_rw;
      S_WB: begin
        PCWrite = 1'b1;
        PCSel   = ctrl_q.is_jump;
      end
      default: begin
        PCWrite = 1'b0;
        PCSel   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed bench: per-instruction handshake model with hand-computed selects and cycle counts.
module tb_rv32i_multicycle_ctrl;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic [2:0]  ImmSel;
  logic        BrEq, BrLT, BrUn, ASel, BSel, RegWEn, PCSel, PCWrite, illegal, bus_err;
  logic [3:0]  ALUSel;
  logic [1:0]  WBSel;

  rv32i_multicycle_ctrl_if bus ();

  rv32i_multicycle_ctrl #(.ACK_TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem     (bus.master),
    .inst    (inst),
    .ImmSel  (ImmSel),
    .BrEq    (BrEq),
    .BrLT    (BrLT),
    .BrUn    (BrUn),
    .ASel    (ASel),
    .BSel    (BSel),
    .ALUSel  (ALUSel),
    .WBSel   (WBSel),
    .RegWEn  (RegWEn),
    .PCSel   (PCSel),
    .PCWrite (PCWrite),
    .illegal (illegal),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-instruction observations.
  int         cyc, ireq_n, dreq_n, memrw_hi_n, regwen_n;
  logic       pcw, s_pcsel, s_regwen_at_pcw, s_asel, s_bsel, s_brun;
  logic [2:0] s_imm;
  logic [3:0] s_alu;
  logic [1:0] s_wb, wb_at_regwen;

  // Starts at a negedge with the DUT in FETCH; acks arrive in the (delay+1)-th req cycle.
  task automatic run_instr(input logic [31:0] ins, input int fd, input int md,
                           input logic beq_v, input logic blt_v, input int limit);
    cyc = 0; ireq_n = 0; dreq_n = 0; memrw_hi_n = 0; regwen_n = 0; pcw = 1'b0;
    for (int c = 0; c < limit; c++) begin
      BrEq = beq_v;
      BrLT = blt_v;
      bus.imem_rdata = ins;
      if (bus.imem_req) begin
        ireq_n++;
        bus.imem_ack = (ireq_n == fd + 1);
      end else begin
        bus.imem_ack = 1'b0;
      end
      if (bus.dmem_req) begin
        dreq_n++;
        bus.dmem_ack = (dreq_n == md + 1);
      end else begin
        bus.dmem_ack = 1'b0;
      end
      #1;
      cyc++;
      if (bus.dmem_req && bus.MemRW) memrw_hi_n++;
      if (RegWEn) begin
        regwen_n++;
        wb_at_regwen = WBSel;
      end
      if (PCWrite) begin
        pcw = 1'b1;
        s_pcsel = PCSel; s_regwen_at_pcw = RegWEn;
        s_imm = ImmSel; s_alu = ALUSel; s_asel = ASel; s_bsel = BSel;
        s_brun = BrUn; s_wb = WBSel;
      end
      @(negedge clk);
      if (pcw) break;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_imem_req", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_req();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    BrEq = 1'b0; BrLT = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_imem_req", 32'(bus.imem_req), 0);
    check_eq("rst_dmem_req", 32'(bus.dmem_req), 0);
    check_eq("rst_inst", inst, 32'h0000_0013);
    check_eq("rst_pcwrite", 32'(PCWrite), 0);
    check_eq("rst_immsel", 32'(ImmSel), 0);
    check_eq("rst_flags", {30'd0, illegal, bus_err}, 0);
    rst_n = 1'b1;
    wait_req();

    // ADDI x1,x0,5: fetch 2 + DECODE/EXEC/WB
    run_instr(32'h0050_0093, 1, 0, 0, 0, 50);
    check_eq("addi_cpi", cyc, 5);
    check_eq("addi_immsel", 32'(s_imm), 1);
    check_eq("addi_bsel", 32'(s_bsel), 1);
    check_eq("addi_alusel", 32'(s_alu), 0);
    check_eq("addi_wbsel", 32'(s_wb), 1);
    check_eq("addi_regwen_with_pcw", 32'(s_regwen_at_pcw), 1);
    check_eq("addi_pcsel", 32'(s_pcsel), 0);
    check_eq("addi_regwen_n", regwen_n, 1);

    // BEQ x1,x2,8 with BrEq=1: taken
    run_instr(32'h0020_8463, 0, 0, 1, 0, 50);
    check_eq("beq_cpi", cyc, 3);
    check_eq("beq_pcsel", 32'(s_pcsel), 1);
    check_eq("beq_immsel", 32'(s_imm), 3);
    check_eq("beq_asel", 32'(s_asel), 1);
    check_eq("beq_brun", 32'(s_brun), 0);
    check_eq("beq_regwen_n", regwen_n, 0);

    // BNE with BrEq=1: not taken
    run_instr(32'h0020_9463, 0, 0, 1, 0, 50);
    check_eq("bne_cpi", cyc, 3);
    check_eq("bne_pcsel", 32'(s_pcsel), 0);
    check_eq("bne_regwen_n", regwen_n, 0);

    // BLTU with BrLT=1: unsigned compare, taken
    run_instr(32'h0020_E463, 0, 0, 0, 1, 50);
    check_eq("bltu_brun", 32'(s_brun), 1);
    check_eq("bltu_pcsel", 32'(s_pcsel), 1);

    // SW x2,0(x1), ack in 4th req cycle
    run_instr(32'h0020_A023, 0, 3, 0, 0, 50);
    check_eq("sw_dreq_cycles", dreq_n, 4);
    check_eq("sw_memrw_cycles", memrw_hi_n, 4);
    check_eq("sw_cpi", cyc, 7);
    check_eq("sw_pcsel", 32'(s_pcsel), 0);
    check_eq("sw_immsel", 32'(s_imm), 2);
    check_eq("sw_regwen_n", regwen_n, 0);

    // LW x3,0(x1), ack in 3rd req cycle
    run_instr(32'h0000_A183, 0, 2, 0, 0, 50);
    check_eq("lw_dreq_cycles", dreq_n, 3);
    check_eq("lw_memrw_cycles", memrw_hi_n, 0);
    check_eq("lw_cpi", cyc, 7);
    check_eq("lw_regwen_n", regwen_n, 1);
    check_eq("lw_wbsel", 32'(wb_at_regwen), 0);

    // LUI x5,0x12345
    run_instr(32'h1234_52B7, 0, 0, 0, 0, 50);
    check_eq("lui_alusel", 32'(s_alu), 10);
    check_eq("lui_bsel", 32'(s_bsel), 1);
    check_eq("lui_immsel", 32'(s_imm), 5);
    check_eq("lui_cpi", cyc, 4);

    // JAL x1,0
    run_instr(32'h0000_00EF, 0, 0, 0, 0, 50);
    check_eq("jal_wbsel", 32'(s_wb), 2);
    check_eq("jal_pcsel", 32'(s_pcsel), 1);
    check_eq("jal_asel", 32'(s_asel), 1);
    check_eq("jal_immsel", 32'(s_imm), 4);

    // SUB x3,x1,x2 and SRAI x1,x1,3
    run_instr(32'h4020_81B3, 0, 0, 0, 0, 50);
    check_eq("sub_alusel", 32'(s_alu), 1);
    run_instr(32'h4030_D093, 0, 0, 0, 0, 50);
    check_eq("srai_alusel", 32'(s_alu), 7);

    // NOP writes x0: PC still advances, no regfile write
    run_instr(32'h0000_0013, 0, 0, 0, 0, 50);
    check_eq("nop_pcwrite", 32'(pcw), 1);
    check_eq("nop_regwen_n", regwen_n, 0);

    // Illegal opcode: trap, no further fetch
    run_instr(32'h0000_007F, 0, 0, 0, 0, 20);
    check_eq("ill_flag", 32'(illegal), 1);
    check_eq("ill_ireq_cycles", ireq_n, 1);
    check_eq("ill_pcwrite", 32'(pcw), 0);
    check_eq("ill_bus_err", 32'(bus_err), 0);
    do_reset();
    check_eq("ill_cleared", 32'(illegal), 0);

    // Asynchronous reset mid-FETCH, then a stale ack during reset/IDLE
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_imem_req", 32'(bus.imem_req), 0);
    check_eq("async_inst", inst, 32'h0000_0013);
    @(negedge clk);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0000_007F;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check_eq("late_ack_fetch", 32'(bus.imem_req), 1);
    @(negedge clk);
    check_eq("late_ack_still_req", 32'(bus.imem_req), 1);
    check_eq("late_ack_inst", inst, 32'h0000_0013);
    run_instr(32'h0050_0093, 0, 0, 0, 0, 50);
    check_eq("post_reset_addi_cpi", cyc, 4);

    // imem_ack withheld: bus error after exactly TMO request cycles
    run_instr(32'h0000_0013, 1000, 0, 0, 0, TMO + 40);
    check_eq("tmo_ireq_cycles", ireq_n, TMO);
    check_eq("tmo_bus_err", 32'(bus_err), 1);
    check_eq("tmo_illegal", 32'(illegal), 0);
    check_eq("tmo_pcwrite", 32'(pcw), 0);
    do_reset();
    check_eq("tmo_cleared", 32'(bus_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
